// File: rtl/piezo_pkg.sv
// Shared piezo note table: nominal full-period counts at 50 MHz and the
// note index / one-hot encoding used by both the tone generator and detector.
package piezo_pkg;

  localparam int NUM_NOTES = 8;

  typedef enum logic [3:0] {
    NOTE_NONE = 4'd0,
    NOTE_C4   = 4'd1,
    NOTE_D4   = 4'd2,
    NOTE_E4   = 4'd3,
    NOTE_F4   = 4'd4,
    NOTE_G4   = 4'd5,
    NOTE_A4   = 4'd6,
    NOTE_B4   = 4'd7,
    NOTE_C5   = 4'd8
  } note_idx_e;

  function automatic logic [31:0] note_period(input int idx);
    case (idx)
      1:       note_period = 32'd191110;
      2:       note_period = 32'd170266;
      3:       note_period = 32'd151685;
      4:       note_period = 32'd143172;
      5:       note_period = 32'd127551;
      6:       note_period = 32'd113636;
      7:       note_period = 32'd101239;
      8:       note_period = 32'd95557;
      default: note_period = 32'd0;
    endcase
  endfunction

  // Generator side: high phase of a square wave for a given note.
  function automatic logic [31:0] note_half_period(input int idx);
    note_half_period = note_period(idx) >> 1;
  endfunction

  function automatic logic [7:0] note_onehot(input logic [3:0] idx);
    if (idx == 4'd0 || idx > 4'd8) begin
      note_onehot = 8'd0;
    end else begin
      note_onehot = 8'd1 << (idx - 4'd1);
    end
  endfunction

  // Window is nominal +/- (nominal >> tol_shift); period_shift rescales the
  // table for a divided clock (0 at 50 MHz).
  function automatic logic [3:0] note_classify(input logic [31:0] meas,
                                               input int tol_shift,
                                               input int period_shift);
    logic [31:0] nom;
    logic [31:0] half;
    note_classify = NOTE_NONE;
    for (int i = 1; i <= NUM_NOTES; i++) begin
      nom  = note_period(i) >> period_shift;
      half = nom >> tol_shift;
      if (meas >= nom - half && meas <= nom + half) begin
        note_classify = 4'(i);
      end
    end
  endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Synchronizes tone_in, detects its rising edges (3 clk after the input rise)
// and measures the edge-to-edge period with a saturating counter.
module tone_period_meter
  import piezo_pkg::*;
#(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] meas,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             prev_q, prev_d;
  logic             edge_q, edge_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d = tone_in;
    sync_d = meta_q;
    prev_d = sync_q;
    edge_d = sync_q & ~prev_q;
    if (edge_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = CNT_MAX;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
      cnt_q  <= cnt_d;
    end
  end

  // A pulse landing on a saturated counter reports the saturated value.
  assign meas       = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
  assign sat        = (cnt_q == CNT_MAX);
  assign edge_pulse = edge_q;

endmodule

// File: rtl/tone_detector.sv
// Piezo tone detector: classifies each measured period against the note table
// and locks a note once two consecutive periods agree.
module tone_detector
  import piezo_pkg::*;
#(
  parameter int TOL_SHIFT    = 6,
  parameter int CNT_W        = 18,
  parameter int PERIOD_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [7:0]       note,
  output logic             note_valid,
  output logic [CNT_W-1:0] period,
  output logic             period_stb
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic             edge_pulse;
  logic             sat;
  logic [CNT_W-1:0] meas;
  logic [3:0]       cls;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [7:0]       note_q, note_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             stb_q, stb_d;

  tone_period_meter #(
    .CNT_W(CNT_W)
  ) u_meter (
    .clk       (clk),
    .rst       (rst),
    .tone_in   (tone_in),
    .edge_pulse(edge_pulse),
    .meas      (meas),
    .sat       (sat)
  );

  assign cls = note_classify(32'(meas), TOL_SHIFT, PERIOD_SHIFT);

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    note_d   = note_q;
    valid_d  = valid_q;
    period_d = period_q;
    stb_d    = 1'b0;
    // Edge pulse outranks saturation; a saturated measurement simply classifies as no note.
    if (edge_pulse) begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
          cand_d  = NOTE_NONE;
        end
        ARMED: begin
          stb_d    = 1'b1;
          period_d = meas;
          if (cls == cand_q && cand_q != NOTE_NONE) begin
            state_d = LOCKED;
            note_d  = note_onehot(cand_q);
            valid_d = 1'b1;
          end else begin
            cand_d = cls;
          end
        end
        LOCKED: begin
          stb_d    = 1'b1;
          period_d = meas;
          if (cls != cand_q) begin
            state_d = ARMED;
            cand_d  = cls;
            note_d  = 8'd0;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          cand_d  = NOTE_NONE;
          note_d  = 8'd0;
          valid_d = 1'b0;
        end
      endcase
    end else if (sat) begin
      state_d = IDLE;
      note_d  = 8'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= NOTE_NONE;
      note_q   <= 8'd0;
      valid_q  <= 1'b0;
      period_q <= '0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      note_q   <= note_d;
      valid_q  <= valid_d;
      period_q <= period_d;
      stb_q    <= stb_d;
    end
  end

  assign note       = note_q;
  assign note_valid = valid_q;
  assign period     = period_q;
  assign period_stb = stb_q;

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector with the note table scaled down (PERIOD_SHIFT=7,
// CNT_W=11) so every scenario fits a short run.
module tb_tone_detector;

  localparam int TS   = 6;
  localparam int CW   = 11;
  localparam int PS   = 7;
  localparam int MAXC = (1 << CW) - 1;
  localparam int NR   = 24;
  localparam int NT   = 25;

  logic          clk;
  logic          rst;
  logic          tone_in;
  logic [7:0]    note;
  logic          note_valid;
  logic [CW-1:0] period;
  logic          period_stb;

  int checks   = 0;
  int failures = 0;

  tone_detector #(
    .TOL_SHIFT   (TS),
    .CNT_W       (CW),
    .PERIOD_SHIFT(PS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tone_in   (tone_in),
    .note      (note),
    .note_valid(note_valid),
    .period    (period),
    .period_stb(period_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         gap;
    logic [7:0] note;
    logic       valid;
    int         per;
    logic       stb;
  } vec_t;

  vec_t tbl [NT];
  int   gaps [NR];

  int m_n;
  int m_prev;
  int m_last;
  int m_per;

  function automatic int model_class(input int g);
    int nominal [8] = '{191110, 170266, 151685, 143172, 127551, 113636, 101239, 95557};
    int nom;
    int half;
    model_class = 0;
    for (int k = 0; k < 8; k++) begin
      nom  = nominal[k] / (1 << PS);
      half = nom / (1 << TS);
      if (g >= nom - half && g <= nom + half) model_class = k + 1;
    end
  endfunction

  function automatic int model_nominal(input int c);
    int nominal [8] = '{191110, 170266, 151685, 143172, 127551, 113636, 101239, 95557};
    model_nominal = nominal[c-1] / (1 << PS);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] en, input logic ev,
                            input int ep, input logic es);
    check({tag, ".note"}, int'(note), int'(en));
    check({tag, ".valid"}, int'(note_valid), int'(ev));
    check({tag, ".period"}, int'(period), ep);
    check({tag, ".stb"}, int'(period_stb), int'(es));
  endtask

  // Called at a negedge: raises tone_in, checks outputs 4 clocks later,
  // drops it after hi cycles and returns at the negedge of the next rise.
  task automatic do_rise(input int gap_after, input int hi, input string tag,
                         input logic [7:0] en, input logic ev, input int ep, input logic es);
    tone_in = 1'b1;
    for (int k = 1; k < gap_after; k++) begin
      @(negedge clk);
      if (k == 4) check_outs(tag, en, ev, ep, es);
      if (k == hi) tone_in = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic timeout_seq();
    repeat (MAXC - 40) @(negedge clk);
    check("timeout.still_locked", int'(note_valid), 1);
    repeat (13) @(negedge clk);
    check("timeout.valid", int'(note_valid), 0);
    check("timeout.note", int'(note), 0);
    check("timeout.period", int'(period), 1493);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int   stb_seen;
    int   nz_seen;
    int   nxt;
    int   cur;
    int   g;
    int   c;
    logic ev;

    rst     = 1'b0;
    tone_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_outs("reset", 8'h00, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    stb_seen = 0;
    nz_seen  = 0;
    repeat (1000) begin
      @(negedge clk);
      if (period_stb) stb_seen = 1;
      if (note != 8'd0 || note_valid || period != '0) nz_seen = 1;
    end
    check("idle.stb_never", stb_seen, 0);
    check("idle.outputs_zero", nz_seen, 0);

    tbl[0]  = '{0,    8'h00, 1'b0, 0,    1'b0};
    tbl[1]  = '{887,  8'h00, 1'b0, 887,  1'b1};
    tbl[2]  = '{887,  8'h20, 1'b1, 887,  1'b1};
    tbl[3]  = '{900,  8'h20, 1'b1, 900,  1'b1};
    tbl[4]  = '{746,  8'h00, 1'b0, 746,  1'b1};
    tbl[5]  = '{746,  8'h80, 1'b1, 746,  1'b1};
    tbl[6]  = '{901,  8'h00, 1'b0, 901,  1'b1};
    tbl[7]  = '{901,  8'h00, 1'b0, 901,  1'b1};
    tbl[8]  = '{874,  8'h00, 1'b0, 874,  1'b1};
    tbl[9]  = '{873,  8'h00, 1'b0, 873,  1'b1};
    tbl[10] = '{1302, 8'h00, 1'b0, 1302, 1'b1};
    tbl[11] = '{1302, 8'h00, 1'b0, 1302, 1'b1};
    tbl[12] = '{1493, 8'h00, 1'b0, 1493, 1'b1};
    tbl[13] = '{1493, 8'h01, 1'b1, 1493, 1'b1};
    tbl[14] = '{0,    8'h00, 1'b0, 1493, 1'b0};
    tbl[15] = '{1330, 8'h00, 1'b0, 1330, 1'b1};
    tbl[16] = '{1330, 8'h02, 1'b1, 1330, 1'b1};
    tbl[17] = '{1185, 8'h00, 1'b0, 1185, 1'b1};
    tbl[18] = '{1185, 8'h04, 1'b1, 1185, 1'b1};
    tbl[19] = '{1118, 8'h00, 1'b0, 1118, 1'b1};
    tbl[20] = '{1118, 8'h08, 1'b1, 1118, 1'b1};
    tbl[21] = '{996,  8'h00, 1'b0, 996,  1'b1};
    tbl[22] = '{996,  8'h10, 1'b1, 996,  1'b1};
    tbl[23] = '{790,  8'h00, 1'b0, 790,  1'b1};
    tbl[24] = '{790,  8'h40, 1'b1, 790,  1'b1};

    for (int i = 0; i < NT; i++) begin
      nxt = (i < NT - 1 && tbl[i+1].gap != 0) ? tbl[i+1].gap : 40;
      do_rise(nxt, nxt / 2, $sformatf("tbl%0d", i), tbl[i].note, tbl[i].valid,
              tbl[i].per, tbl[i].stb);
      if (i < NT - 1 && tbl[i+1].gap == 0) timeout_seq();
    end

    // Asynchronous reset while B4 is locked, between clock edges.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_outs("rst_async", 8'h00, 1'b0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    cur = 0;
    for (int i = 0; i < NR; i++) begin
      if (!(cur != 0 && $urandom_range(0, 2) != 0)) begin
        cur = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 8));
      end
      if (cur == 0) begin
        g = $urandom_range(700, 1600);
      end else begin
        c = model_nominal(cur) / (1 << TS);
        g = model_nominal(cur) - c + int'($urandom_range(0, 2 * c));
      end
      gaps[i] = g;
    end

    do_rise(887, 443, "relock1", 8'h00, 1'b0, 0, 1'b0);
    do_rise(887, 443, "relock2", 8'h00, 1'b0, 887, 1'b1);
    do_rise(gaps[0], gaps[0] / 2, "relock3", 8'h20, 1'b1, 887, 1'b1);

    m_n    = 2;
    m_prev = 6;
    m_last = 6;
    m_per  = 887;
    for (int i = 0; i < NR; i++) begin
      m_prev = m_last;
      m_last = model_class(gaps[i]);
      m_n++;
      m_per = gaps[i];
      ev  = (m_n >= 2 && m_prev == m_last && m_last != 0);
      nxt = (i < NR - 1) ? gaps[i+1] : 40;
      do_rise(nxt, $urandom_range(4, nxt - 4), $sformatf("rnd%0d_g%0d", i, gaps[i]),
              ev ? (8'd1 << (m_last - 1)) : 8'd0, ev, m_per, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
